// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-cycle operand forwarding and load-use hazard detection.
// Define ID_EX_FWD_EN to enable forwarding; otherwise RAW hazards on EX/EX-MEM producers stall instead.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_src1_pc,
  input  logic            id_src2_imm,
  input  logic [3:0]      id_alu_op,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            exmem_reg_write,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_result,
  output logic            hazard_o,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [3:0]      ex_alu_op,
  output logic [RA_W-1:0] ex_rd,
  output logic [XLEN-1:0] ex_operand1,
  output logic [XLEN-1:0] ex_operand2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc
);
  logic            r_valid, r_reg_write, r_mem_read, r_mem_write, r_src1_pc, r_src2_imm;
  logic [3:0]      r_alu_op;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm, r_pc;
  logic [XLEN-1:0] w_fwd1, w_fwd2;
  logic            w_lu, w_dep, w_bub;
`ifdef ID_EX_FWD_EN
  logic [RA_W-1:0] r_rs1, r_rs2;
  always_comb begin
    w_fwd1 = (exmem_reg_write && exmem_rd == r_rs1 && r_rs1 != '0) ? exmem_result :
             (memwb_reg_write && memwb_rd == r_rs1 && r_rs1 != '0) ? memwb_result : r_rs1_data;
    w_fwd2 = (exmem_reg_write && exmem_rd == r_rs2 && r_rs2 != '0) ? exmem_result :
             (memwb_reg_write && memwb_rd == r_rs2 && r_rs2 != '0) ? memwb_result : r_rs2_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (!stall_i) begin
      r_rs1 <= w_bub ? '0 : id_rs1;
      r_rs2 <= w_bub ? '0 : id_rs2;
    end
`else
  // The register file writes through for MEM/WB, so these ports carry nothing this stage needs.
  logic w_unused;
  assign w_unused = ^{memwb_reg_write, memwb_rd, memwb_result, exmem_result};
  always_comb begin
    w_fwd1 = r_rs1_data;
    w_fwd2 = r_rs2_data;
  end
`endif
  always_comb begin
    w_lu = r_valid & r_mem_read & (r_rd != '0) & id_valid & ((id_rs1 == r_rd) | (id_rs2 == r_rd));
`ifdef ID_EX_FWD_EN
    w_dep = 1'b0;
`else
    w_dep = id_valid & (
      ((id_rs1 != '0) & ((r_valid & r_reg_write & (id_rs1 == r_rd)) | (exmem_reg_write & (id_rs1 == exmem_rd)))) |
      ((id_rs2 != '0) & ((r_valid & r_reg_write & (id_rs2 == r_rd)) | (exmem_reg_write & (id_rs2 == exmem_rd)))));
`endif
    hazard_o = ~rst & ~stall_i & (w_lu | w_dep);
    w_bub = flush_i | hazard_o;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_src1_pc   <= 1'b0;
      r_src2_imm  <= 1'b0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
    end else if (!stall_i) begin
      r_valid     <= ~w_bub & id_valid;
      r_reg_write <= ~w_bub & id_reg_write;
      r_mem_read  <= ~w_bub & id_mem_read;
      r_mem_write <= ~w_bub & id_mem_write;
      r_src1_pc   <= ~w_bub & id_src1_pc;
      r_src2_imm  <= ~w_bub & id_src2_imm;
      r_alu_op    <= w_bub ? '0 : id_alu_op;
      r_rd        <= w_bub ? '0 : id_rd;
      r_rs1_data  <= w_bub ? '0 : id_rs1_data;
      r_rs2_data  <= w_bub ? '0 : id_rs2_data;
      r_imm       <= w_bub ? '0 : id_imm;
      r_pc        <= w_bub ? '0 : id_pc;
    end
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_alu_op     = r_alu_op;
  assign ex_rd         = r_rd;
  assign ex_pc         = r_pc;
  assign ex_operand1   = r_src1_pc ? r_pc : w_fwd1;
  assign ex_operand2   = r_src2_imm ? r_imm : w_fwd2;
  assign ex_store_data = w_fwd2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage, checked every cycle against a behavioural model.
module tb_id_ex_stage;
  logic clk = 0, rst = 1, stall_i = 0, flush_i = 0;
  logic id_valid = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_src1_pc = 0, id_src2_imm = 0;
  logic [3:0] id_alu_op = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
  logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0, id_pc = 0, exmem_result = 0, memwb_result = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic hazard_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd;
  logic [31:0] ex_operand1, ex_operand2, ex_store_data, ex_pc;
  int n_pass = 0, n_total = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
    .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_result(exmem_result), .memwb_result(memwb_result),
    .hazard_o(hazard_o), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_operand1(ex_operand1),
    .ex_operand2(ex_operand2), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, rw, mr, mw, s1pc, s2imm;
    logic [3:0] op;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } ex_t;
  ex_t m;

  function automatic logic dep(input logic [4:0] r);
    return r != 0 && ((m.v && m.rw && r == m.rd) || (exmem_reg_write && r == exmem_rd));
  endfunction

  function automatic logic exp_hazard();
    logic h;
    if (rst || stall_i || !id_valid) return 1'b0;
    h = m.v && m.mr && m.rd != 0 && (id_rs1 == m.rd || id_rs2 == m.rd);
`ifndef ID_EX_FWD_EN
    h = h || dep(id_rs1) || dep(id_rs2);
`endif
    return h;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
    if (r != 0 && exmem_reg_write && r == exmem_rd) return exmem_result;
    if (r != 0 && memwb_reg_write && r == memwb_rd) return memwb_result;
`endif
    return d;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m <= '0;
    else if (stall_i) m <= m;
    else if (flush_i || exp_hazard()) m <= '0;
    else m <= '{v:id_valid, rw:id_reg_write, mr:id_mem_read, mw:id_mem_write, s1pc:id_src1_pc,
                s2imm:id_src2_imm, op:id_alu_op, rs1:id_rs1, rs2:id_rs2, rd:id_rd,
                d1:id_rs1_data, d2:id_rs2_data, imm:id_imm, pc:id_pc};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
  endtask

  always @(negedge clk) begin
    chk("hazard_o", {31'b0, hazard_o}, {31'b0, exp_hazard()});
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.v});
    chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
    chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
    chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m.mw});
    chk("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, m.op});
    chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_operand1", ex_operand1, m.s1pc ? m.pc : fwd(m.rs1, m.d1));
    chk("ex_operand2", ex_operand2, m.s2imm ? m.imm : fwd(m.rs2, m.d2));
    chk("ex_store_data", ex_store_data, fwd(m.rs2, m.d2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, rw, mr, mw, s1, s2, input logic [3:0] op,
                        input logic [4:0] r1, r2, rd, input logic [31:0] d1, d2, imm, pc);
    id_valid = v; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_src1_pc = s1; id_src2_imm = s2; id_alu_op = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; memwb_reg_write = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", {31'b0, ex_valid}, 0);
    chk("rst_op1", ex_operand1, 0);
    rst = 0;
    set_id(1, 1, 0, 0, 0, 0, 4'b0001, 1, 2, 6, 7, 3, 0, 32'h40);
    tick();
    chk("load_valid", {31'b0, ex_valid}, 1);
    #2 rst = 1;
    #1;
    chk("midrst_valid", {31'b0, ex_valid}, 0);
    chk("midrst_op1", ex_operand1, 0);
    chk("midrst_alu_op", {28'b0, ex_alu_op}, 0);
    chk("midrst_pc", ex_pc, 0);
    tick();
    rst = 0;
    tick();
    #1;
    chk("first_op1", ex_operand1, 7);
    chk("first_op2", ex_operand2, 3);
    chk("first_alu_op", {28'b0, ex_alu_op}, 1);
    // forwarding priority: EX/MEM over MEM/WB, x0 never forwarded
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5, 0, 7, 32'h55, 0, 0, 32'h44);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h22;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_exmem", ex_operand1, 32'h11);
`else
    chk("fwd_exmem", ex_operand1, 32'h55);
`endif
    exmem_reg_write = 0;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_memwb", ex_operand1, 32'h22);
`else
    chk("fwd_memwb", ex_operand1, 32'h55);
`endif
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFF;
    #1;
    chk("x0_op2", ex_operand2, 0);
    chk("x0_store", ex_store_data, 0);
    // load-use: lw x3 in EX, dependent on x3 in ID
    no_fwd();
    set_id(1, 1, 1, 0, 0, 1, 4'b0000, 1, 0, 3, 32'h100, 0, 4, 32'h48);
    tick();
    set_id(1, 1, 0, 0, 0, 0, 4'b0000, 3, 0, 8, 0, 0, 0, 32'h4C);
    #1;
    chk("lu_hazard", {31'b0, hazard_o}, 1);
    tick();
    chk("lu_bubble", {31'b0, ex_valid}, 0);
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h104;
    #1;
`ifdef ID_EX_FWD_EN
    chk("lu_released", {31'b0, hazard_o}, 0);
    tick();
    no_fwd();
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hABCD;
    id_valid = 0;
    #1;
    chk("lu_dep_valid", {31'b0, ex_valid}, 1);
    chk("lu_dep_op1", ex_operand1, 32'hABCD);
`else
    chk("nofwd_exmem_hazard", {31'b0, hazard_o}, 1);
    tick();
    no_fwd();
    id_rs1_data = 32'hABCD;
    tick();
    id_valid = 0;
    #1;
    chk("lu_dep_valid", {31'b0, ex_valid}, 1);
    chk("lu_dep_op1", ex_operand1, 32'hABCD);
`endif
    // stall holds, then flush with hazard pending gives a bubble
    no_fwd();
    set_id(1, 1, 1, 0, 0, 0, 4'b0101, 1, 2, 9, 32'h1234, 32'h5678, 0, 32'h50);
    tick();
    set_id(1, 1, 0, 0, 0, 0, 4'b0111, 9, 2, 10, 32'hAAAA, 32'hBBBB, 0, 32'h54);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu_op", {28'b0, ex_alu_op}, 4'b0101);
      chk("stall_op1", ex_operand1, 32'h1234);
      chk("stall_hazard_gated", {31'b0, hazard_o}, 0);
    end
    stall_i = 0; flush_i = 1;
    #1;
    chk("flush_hazard_seen", {31'b0, hazard_o}, 1);
    tick();
    flush_i = 0;
    id_valid = 0;
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_reg_write", {31'b0, ex_reg_write}, 0);
    chk("flush_op1", ex_operand1, 0);
    // PC/immediate operand selection; store data keeps rs2
    set_id(1, 0, 0, 1, 1, 1, 4'b0000, 0, 10, 0, 0, 32'h77, 32'hFFFFF800, 32'h400);
    tick();
    id_valid = 0;
    memwb_rd = 10; memwb_reg_write = 1; memwb_result = 32'h99;
    #1;
    chk("pc_op1", ex_operand1, 32'h400);
    chk("imm_op2", ex_operand2, 32'hFFFFF800);
`ifdef ID_EX_FWD_EN
    chk("store_fwd", ex_store_data, 32'h99);
`else
    chk("store_fwd", ex_store_data, 32'h77);
`endif
    chk("store_mem_write", {31'b0, ex_mem_write}, 1);
    no_fwd();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core: registers decoded instruction fields at each clock, resolves operand forwarding from the EX/MEM and MEM/WB stages, and presents the selected opcode and operands to the EX-stage ALU. It also detects load-use hazards, holds on downstream stall, inserts bubbles, and is cleared by branch flushes.

## Interface
- XLEN, 32: datapath width
- RA_W, 5: register address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  downstream stall; hold all stage registers
- flush_i  in  1  branch/jump redirect; kill instruction entering stage
- id_valid, id_reg_write, id_mem_read, id_mem_write, id_src1_pc, id_src2_imm  in  1 each  decoded control
- id_alu_op  in  4  ALU opcode (0000 add … 1001 sltu)
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  register-file data, immediate, PC
- exmem_reg_write, memwb_reg_write  in  1  writeback enables of later stages
- exmem_rd, memwb_rd  in  RA_W  destination registers of later stages
- exmem_result, memwb_result  in  XLEN  forwardable results
- hazard_o  out  1  load-use hazard; upstream holds IF/ID
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_alu_op  out  4  registered ALU opcode
- ex_rd  out  RA_W  registered destination
- ex_operand1, ex_operand2, ex_store_data, ex_pc  out  XLEN  ALU operands, store data, PC

## Operation
- Register update priority at each posedge: rst > stall_i (hold) > flush_i (bubble) > hazard_o (bubble) > load ID fields.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; all other fields cleared to 0.
- Forwarding applies to the registered rs1/rs2 values, combinationally in the EX cycle:
  - rsN matches exmem_rd, exmem_reg_write=1 and rsN≠0 → exmem_result.
  - else matches memwb_rd, memwb_reg_write=1 and rsN≠0 → memwb_result.
  - else the registered register-file data. x0 is never forwarded.
- ex_operand1 = ex_pc if src1_pc else forwarded rs1; ex_operand2 = imm if src2_imm else forwarded rs2; ex_store_data = forwarded rs2 always.
- hazard_o = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd); combinational. It is gated off while stall_i=1.
- Widths: all data XLEN and unmodified; no sign or width conversion in this stage.

## Timing
- Reset (async assert, sync release): every output 0 (ex_alu_op=0000, ex_valid=0); hazard_o=0.
- Latency: one cycle from ID inputs to ex_* outputs; forwarding adds zero cycles.
- Load-use: one-cycle bubble; the dependent instruction enters on the next edge, receiving the load data through MEM/WB forwarding.
- flush_i and hazard_o in the same cycle: flush wins; result is the same bubble.
- stall_i with flush_i: stall wins; flush must be held by its source until stall_i drops.
- rst mid-stream discards the held instruction immediately, without waiting for a clock edge.

## Configuration
- ID_EX_FWD_EN defined: forwarding as above; hazard_o covers load-use only.
- Undefined: operands come from the registered register-file data only (the register file writes through for MEM/WB). hazard_o additionally asserts for any id_rs1/id_rs2 (≠0) matching ex_rd with ex_reg_write & ex_valid, or exmem_rd with exmem_reg_write.

## Test plan
- Reset: assert rst mid-operation with ex_valid=1 → all outputs 0 immediately; after release, first load with id_alu_op=0001, rs1_data=7, rs2_data=3 → next cycle ex_operand1=7, ex_operand2=3, ex_alu_op=0001.
- Forward priority: ex rs1=5, exmem_rd=5/result=0x11, memwb_rd=5/result=0x22, both write enables set → ex_operand1=0x11; clear exmem_reg_write → 0x22.
- x0: rs2=0, exmem_rd=0, exmem_reg_write=1, result=0xFF → ex_operand2 = registered rs2_data (0).
- Load-use: lw x3 in EX, ID instruction has rs1=3 → hazard_o=1; next cycle ex_valid=0; following cycle the dependent instruction is in EX, and memwb_result=0xABCD appears on ex_operand1.
- Stall/flush: stall_i=1 for 3 cycles → ex_* unchanged; then flush_i=1 together with hazard condition → bubble, ex_reg_write=0.
- Without ID_EX_FWD_EN: exmem_rd=4 with write enable and id_rs2=4 → hazard_o=1.
